// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, null tag and source encoding for the CDB arbiter slice.
package cdb_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 5;
  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_LSB : SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source handshakes, rollback and CDB broadcast bundle; master drives sources, slave is the arbiter.
interface cdb_arbiter_if #(
  parameter int WORD_W = cdb_arbiter_pkg::WORD_W,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W
);

  logic              rob_rollback_in;
  logic              alu_valid_in;
  logic [WORD_W-1:0] alu_result_in;
  logic [TAG_W-1:0]  alu_tag_in;
  logic              alu_ready_out;
  logic              lsb_valid_in;
  logic [WORD_W-1:0] lsb_result_in;
  logic [TAG_W-1:0]  lsb_tag_in;
  logic              lsb_ready_out;
  logic              cdb_valid_out;
  logic [WORD_W-1:0] cdb_result_out;
  logic [TAG_W-1:0]  cdb_tag_out;

  modport master (
    output rob_rollback_in,
    output alu_valid_in, alu_result_in, alu_tag_in,
    output lsb_valid_in, lsb_result_in, lsb_tag_in,
    input  alu_ready_out, lsb_ready_out,
    input  cdb_valid_out, cdb_result_out, cdb_tag_out
  );

  modport slave (
    input  rob_rollback_in,
    input  alu_valid_in, alu_result_in, alu_tag_in,
    input  lsb_valid_in, lsb_result_in, lsb_tag_in,
    output alu_ready_out, lsb_ready_out,
    output cdb_valid_out, cdb_result_out, cdb_tag_out
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result queue: power-of-two DEPTH ring buffer with flush, count, full and empty.
module cdb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  assign do_push   = push & ~full & ~flush;
  assign do_pop    = pop & ~empty & ~flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU and LSB result queues onto one registered CDB.
// Optional CDB_BYPASS_EN lets an empty, granted source's input go straight to the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int WORD_W = cdb_arbiter_pkg::WORD_W,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int ENTRY_W = WORD_W + TAG_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic               alu_push, alu_pop, alu_full, alu_empty;
  logic               lsb_push, lsb_pop, lsb_full, lsb_empty;
  logic [ENTRY_W-1:0] alu_head, lsb_head;
  logic [CNT_W-1:0]   alu_count, lsb_count;
  logic               alu_cand, lsb_cand;
  logic               alu_bypass, lsb_bypass;
  logic               grant_valid;
  src_e               grant_src;
  src_e               last_grant;
  logic [ENTRY_W-1:0] grant_data;

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.rob_rollback_in),
    .push      (alu_push),
    .push_data ({bus.alu_result_in, bus.alu_tag_in}),
    .pop       (alu_pop),
    .head_data (alu_head),
    .count     (alu_count),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.rob_rollback_in),
    .push      (lsb_push),
    .push_data ({bus.lsb_result_in, bus.lsb_tag_in}),
    .pop       (lsb_pop),
    .head_data (lsb_head),
    .count     (lsb_count),
    .full      (lsb_full),
    .empty     (lsb_empty)
  );

  assign bus.alu_ready_out = (alu_count < DEPTH_CNT);
  assign bus.lsb_ready_out = (lsb_count < DEPTH_CNT);

  // With bypass, a valid input into an empty queue competes as if it were already queued.
  always_comb begin
    alu_cand   = ~alu_empty;
    lsb_cand   = ~lsb_empty;
`ifdef CDB_BYPASS_EN
    alu_cand   = ~alu_empty | bus.alu_valid_in;
    lsb_cand   = ~lsb_empty | bus.lsb_valid_in;
`endif
    grant_valid = (alu_cand | lsb_cand) & ~bus.rob_rollback_in;
    grant_src   = SRC_ALU;
    if (alu_cand && lsb_cand) grant_src = other_src(last_grant);
    else if (lsb_cand)        grant_src = SRC_LSB;

    alu_bypass = 1'b0;
    lsb_bypass = 1'b0;
`ifdef CDB_BYPASS_EN
    alu_bypass = grant_valid & (grant_src == SRC_ALU) & alu_empty;
    lsb_bypass = grant_valid & (grant_src == SRC_LSB) & lsb_empty;
`endif
    alu_pop  = grant_valid & (grant_src == SRC_ALU) & ~alu_empty;
    lsb_pop  = grant_valid & (grant_src == SRC_LSB) & ~lsb_empty;
    alu_push = bus.alu_valid_in & ~alu_full & ~bus.rob_rollback_in & ~alu_bypass;
    lsb_push = bus.lsb_valid_in & ~lsb_full & ~bus.rob_rollback_in & ~lsb_bypass;

    if (grant_src == SRC_ALU)
      grant_data = alu_bypass ? {bus.alu_result_in, bus.alu_tag_in} : alu_head;
    else
      grant_data = lsb_bypass ? {bus.lsb_result_in, bus.lsb_tag_in} : lsb_head;
  end

  // The pointer only moves on contested grants; reset leaves it favouring the ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= SRC_LSB;
    end else if (grant_valid && alu_cand && lsb_cand) begin
      last_grant <= grant_src;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cdb_valid_out  <= 1'b0;
      bus.cdb_result_out <= '0;
      bus.cdb_tag_out    <= TAG_W'(NULL_TAG);
    end else begin
      bus.cdb_valid_out <= grant_valid;
      if (grant_valid) begin
        {bus.cdb_result_out, bus.cdb_tag_out} <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cdb_arbiter;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [WORD_W-1:0] res;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cdb_arbiter_if #(.WORD_W(WORD_W), .TAG_W(TAG_W)) bus ();

  cdb_arbiter #(.WORD_W(WORD_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  entry_t            q_alu[$];
  entry_t            q_lsb[$];
  bit                last_alu;
  logic              exp_valid;
  logic [WORD_W-1:0] exp_res;
  logic [TAG_W-1:0]  exp_tag;
  int                n_checks = 0;
  int                n_err = 0;
  logic [TAG_W-1:0]  got_tags[$];

  task automatic modelReset();
    q_alu.delete();
    q_lsb.delete();
    last_alu  = 1'b0;
    exp_valid = 1'b0;
    exp_res   = '0;
    exp_tag   = '0;
  endtask

  // One clock of the reference behaviour, evaluated on the state before the edge.
  task automatic modelStep(input bit av, input entry_t ae, input bit lv, input entry_t le, input bit rb);
    bit a_acc, l_acc, a_has, l_has, a_cand, l_cand, pick_a, pick_l;
    entry_t e;
    if (rb) begin
      q_alu.delete();
      q_lsb.delete();
      exp_valid = 1'b0;
      return;
    end
    a_acc = av && (q_alu.size() < DEPTH);
    l_acc = lv && (q_lsb.size() < DEPTH);
    a_has = q_alu.size() > 0;
    l_has = q_lsb.size() > 0;
`ifdef CDB_BYPASS_EN
    a_cand = a_has || av;
    l_cand = l_has || lv;
`else
    a_cand = a_has;
    l_cand = l_has;
`endif
    if (a_cand && l_cand) begin
      pick_a   = !last_alu;
      pick_l   = last_alu;
      last_alu = pick_a;
    end else begin
      pick_a = a_cand;
      pick_l = l_cand;
    end
    e = '0;
    if (pick_a) begin
      if (a_has) e = q_alu.pop_front();
      else begin e = ae; a_acc = 1'b0; end
    end else if (pick_l) begin
      if (l_has) e = q_lsb.pop_front();
      else begin e = le; l_acc = 1'b0; end
    end
    exp_valid = pick_a || pick_l;
    if (exp_valid) begin
      exp_res = e.res;
      exp_tag = e.tag;
    end
    if (a_acc) q_alu.push_back(ae);
    if (l_acc) q_lsb.push_back(le);
  endtask

  task automatic checkOutput(input string name);
    n_checks++;
    assert (bus.cdb_valid_out === exp_valid) else begin
      n_err++;
      $error("[TB] FAIL %s cdb_valid got %0b want %0b", name, bus.cdb_valid_out, exp_valid);
    end
    n_checks++;
    assert (bus.cdb_result_out === exp_res) else begin
      n_err++;
      $error("[TB] FAIL %s cdb_result got %h want %h", name, bus.cdb_result_out, exp_res);
    end
    n_checks++;
    assert (bus.cdb_tag_out === exp_tag) else begin
      n_err++;
      $error("[TB] FAIL %s cdb_tag got %0d want %0d", name, bus.cdb_tag_out, exp_tag);
    end
    n_checks++;
    assert (bus.alu_ready_out === (q_alu.size() < DEPTH)) else begin
      n_err++;
      $error("[TB] FAIL %s alu_ready got %0b want %0b", name, bus.alu_ready_out, q_alu.size() < DEPTH);
    end
    n_checks++;
    assert (bus.lsb_ready_out === (q_lsb.size() < DEPTH)) else begin
      n_err++;
      $error("[TB] FAIL %s lsb_ready got %0b want %0b", name, bus.lsb_ready_out, q_lsb.size() < DEPTH);
    end
  endtask

  // Drive one cycle of inputs, advance the model and DUT, then compare just after the edge.
  task automatic applyStimulus(input string name, input bit av, input logic [WORD_W-1:0] ar,
                               input logic [TAG_W-1:0] at, input bit lv, input logic [WORD_W-1:0] lr,
                               input logic [TAG_W-1:0] lt, input bit rb);
    bus.alu_valid_in    = av;
    bus.alu_result_in   = ar;
    bus.alu_tag_in      = at;
    bus.lsb_valid_in    = lv;
    bus.lsb_result_in   = lr;
    bus.lsb_tag_in      = lt;
    bus.rob_rollback_in = rb;
    modelStep(av, '{res: ar, tag: at}, lv, '{res: lr, tag: lt}, rb);
    @(posedge clk);
    #1;
    checkOutput(name);
    if (bus.cdb_valid_out === 1'b1) got_tags.push_back(bus.cdb_tag_out);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) applyStimulus(name, 0, '0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    logic [TAG_W-1:0] order_exp[4];
    order_exp = '{5'd1, 5'd9, 5'd2, 5'd10};
    bus.alu_valid_in = 0; bus.alu_result_in = '0; bus.alu_tag_in = '0;
    bus.lsb_valid_in = 0; bus.lsb_result_in = '0; bus.lsb_tag_in = '0;
    bus.rob_rollback_in = 0;
    modelReset();

    #3 checkOutput("reset_state");
    #9 rst = 1'b1;
    #1 checkOutput("after_release");

    @(posedge clk); #1;
    applyStimulus("alu_single", 1, 32'h11, 5'd3, 0, '0, '0, 0);
    idle("alu_single_drain", 3);

    got_tags.delete();
    applyStimulus("both_1", 1, 32'hA1, 5'd1, 1, 32'hB9, 5'd9, 0);
    applyStimulus("both_2", 1, 32'hA2, 5'd2, 1, 32'hBA, 5'd10, 0);
    idle("both_drain", 4);
    n_checks++;
    assert (got_tags.size() == 4) else begin
      n_err++;
      $error("[TB] FAIL order_count got %0d want 4", got_tags.size());
    end
    for (int i = 0; i < 4 && i < got_tags.size(); i++) begin
      n_checks++;
      assert (got_tags[i] === order_exp[i]) else begin
        n_err++;
        $error("[TB] FAIL order_%0d got %0d want %0d", i, got_tags[i], order_exp[i]);
      end
    end

    for (int i = 0; i < 5; i++)
      applyStimulus("backpressure", 1, 32'h100 + i, 5'(4 + i), 1, 32'h200 + i, 5'(16 + i), 0);
    applyStimulus("rollback", 1, 32'hDEAD, 5'd7, 1, 32'hBEEF, 5'd8, 1);
    idle("post_rollback", 3);

    for (int i = 0; i < 300; i++)
      applyStimulus("random", $urandom_range(0, 1) == 1, $urandom, 5'($urandom_range(1, 31)),
                    $urandom_range(0, 1) == 1, $urandom, 5'($urandom_range(1, 31)),
                    $urandom_range(0, 19) == 0);

    for (int i = 0; i < 4; i++)
      applyStimulus("fill", 1, 32'h300 + i, 5'(20 + i), 1, 32'h400 + i, 5'(24 + i), 0);
    bus.alu_valid_in = 0;
    bus.lsb_valid_in = 0;
    #2 rst = 1'b0;
    modelReset();
    #1 checkOutput("async_reset");
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("reset_release");
    idle("post_reset_idle", 4);
    applyStimulus("post_reset_push", 0, '0, '0, 1, 32'h55, 5'd6, 0);
    idle("post_reset_drain", 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
